nn_reg_manager: RTL and testbench
=================================

Name: nn_reg_manager

Overview:
- Memory-mapped register manager for the two-layer inference datapath. Generalisation of the existing weight manager to arbitrary layer sizes.
- Holds all layer weights and the input vector, and exposes them packed to the compute engine.
- Sequences one inference per start command through a start/result handshake, then captures the results into read-only output registers.
- Adds read-back, status/error reporting and soft clear.

Parameters:
WIDTH, 4, host data bus width (>=4)
WIDTH_W, 9, weight width; in_d sign-extended to WIDTH_W (truncated if WIDTH>WIDTH_W)
LENGHT_I, 2, input vector length
LENGHT_MID, 2, hidden layer length
LENGHT_O, 2, output vector length
N_W, LENGHT_I*LENGHT_MID+LENGHT_MID*LENGHT_O, weight count (derived)
WIDTH_ADDR, $clog2(2+N_W+LENGHT_I+LENGHT_O), address width (derived)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
address  in  WIDTH_ADDR  register address
write  in  1  write strobe, one access per cycle
read  in  1  read strobe
in_d  in  WIDTH  write data
out_d  out  WIDTH  read data
ready  out  1  read data valid pulse
wr  out  1  weight-written pulse
down  out  1  inference complete (level)
w_o  out  N_W*WIDTH_W  packed weights, index 0 in LSBs
x_o  out  LENGHT_I*WIDTH  packed input vector
start_o  out  1  compute start pulse
res_valid_i  in  1  compute result valid
res_i  in  LENGHT_O*WIDTH  compute results, index 0 in LSBs

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. Reset clears all registers, all outputs go to 0, and the FSM enters IDLE.
- Address map:
  - 0: CTRL (write-only). bit0 start, bit1 soft clear. Self-clearing; reads return 0.
  - 1: STATUS. bit0 busy, bit1 done, bit2 err, others 0. bit2 is write-1-to-clear.
  - 2..N_W+1: weights 0..N_W-1.
  - next LENGHT_I addresses: inputs.
  - next LENGHT_O addresses: outputs (read-only).
  - Any address above the map is invalid.
- Writes take effect on the clk edge while write=1.
- wr pulses 1 cycle, the cycle after each accepted weight write.
- Reads: out_d is registered and ready=1 the cycle after read=1 (latency 1). out_d holds its value between reads.
- Simultaneous read and write: the write takes effect and the read returns the pre-write value.
- FSM states: IDLE, START, RUN, DONE.
  - IDLE/DONE: a start write moves to START and clears done.
  - START: start_o=1 for exactly 1 cycle, then go to RUN.
  - RUN: wait for res_valid_i. Capture res_i into the output registers, then go to DONE.
  - DONE: down=1 (also reflected as status done=1). down stays high until the next start or soft clear.
- busy = state in {START, RUN}.
- Start written while busy: ignored, no error.
- res_valid_i outside RUN: ignored.
- Writes to weight or input registers while busy: ignored, err set. w_o and x_o are stable for the whole run.
- Setting err: writes to outputs or invalid addresses, and reads of invalid addresses, set err. Invalid reads return 0 with ready still pulsed.
- Soft clear, in any state:
  - FSM goes to IDLE, start_o is deasserted, down, err and the output registers are cleared.
  - Weights and inputs are retained.
  - Takes priority over start if both bits are written together.
- Reset mid-run: immediate return to IDLE, all state cleared.

Optional Feature:
- Macro NN_MGR_WRDBK_EN.
- Defined: weight and input addresses read back their stored value. Weights are truncated to the low WIDTH bits of WIDTH_W.
- Undefined: weight and input addresses are write-only. Reads return 0 and pulse ready, with no err.

Test Plan:
- Reset release, then write in_d=4'b1111 to addr 2 -> w_o[8:0]=9'h1FF, wr high exactly 1 cycle after the write. Write 4'd3 to addr 3 -> w_o[17:9]=9'h003.
- Write inputs 1 and 5 to addrs 10 and 11, then write CTRL=1 -> x_o=8'h51, start_o high 1 cycle, STATUS reads 4'b0001. Drive res_valid_i with res_i=8'hA7 -> down=1, addr 12 reads 4'h7, addr 13 reads 4'hA, STATUS reads 4'b0010.
- During RUN write 4'h6 to addr 4 -> w_o unchanged, STATUS bit2=1. Write 4'b0100 to STATUS -> err cleared.
- Write to addr 12, and read addr 15 -> err set, read returns 0 with ready pulsed.
- CTRL=4'b0011 while in DONE -> state IDLE, down=0, outputs read 0, weights retained.
- Assert reset in RUN, then res_valid_i=1 -> no capture, down stays 0. Read weight addr with and without NN_MGR_WRDBK_EN -> stored value vs 0.

Source files
------------

// File: rtl/nn_reg_manager.sv
// Memory-mapped weight/input register file that sequences one inference per start.
// Define NN_MGR_WRDBK_EN to make weight and input registers readable.
module nn_reg_manager #(
  parameter int WIDTH      = 4,
  parameter int WIDTH_W    = 9,
  parameter int LENGHT_I   = 2,
  parameter int LENGHT_MID = 2,
  parameter int LENGHT_O   = 2,
  parameter int N_W        = LENGHT_I*LENGHT_MID
                             + LENGHT_MID*LENGHT_O,
  parameter int WIDTH_ADDR =
    $clog2(2+N_W+LENGHT_I+LENGHT_O)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH_ADDR-1:0]     address,
  input  logic                      write,
  input  logic                      read,
  input  logic [WIDTH-1:0]          in_d,
  output logic [WIDTH-1:0]          out_d,
  output logic                      ready,
  output logic                      wr,
  output logic                      down,
  output logic [N_W*WIDTH_W-1:0]    w_o,
  output logic [LENGHT_I*WIDTH-1:0] x_o,
  output logic                      start_o,
  input  logic                      res_valid_i,
  input  logic [LENGHT_O*WIDTH-1:0] res_i
);

  localparam logic [31:0] W_BASE = 32'd2;
  localparam logic [31:0] I_BASE = W_BASE + 32'(N_W);
  localparam logic [31:0] O_BASE = I_BASE + 32'(LENGHT_I);
  localparam logic [31:0] N_REG  = O_BASE + 32'(LENGHT_O);

  typedef enum logic [1:0] {
    IDLE, START, RUN, DONE
  } state_t;

  state_t state, state_nx;

  logic [N_W*WIDTH_W-1:0]    w_q;
  logic [LENGHT_I*WIDTH-1:0] x_q;
  logic [LENGHT_O*WIDTH-1:0] o_q;
  logic                      err_q, err_d;
  logic                      busy;

  logic [31:0]        a;
  logic               is_ctrl, is_stat;
  logic               is_w, is_x, is_o, is_bad;
  logic               start_cmd, clr_cmd;
  logic               w_we, x_we, capture;
  logic               err_set, err_clr;
  logic [WIDTH_W-1:0] wdata_w;
  logic [WIDTH-1:0]   rdata;

  assign a       = 32'(address);
  assign is_ctrl = (a == 32'd0);
  assign is_stat = (a == 32'd1);
  assign is_w    = (a >= W_BASE) && (a < I_BASE);
  assign is_x    = (a >= I_BASE) && (a < O_BASE);
  assign is_o    = (a >= O_BASE) && (a < N_REG);
  assign is_bad  = (a >= N_REG);

  // clear wins over start when both bits are written together
  assign clr_cmd   = write && is_ctrl && in_d[1];
  assign start_cmd = write && is_ctrl && in_d[0]
                     && !in_d[1];

  assign w_we    = write && is_w && !busy;
  assign x_we    = write && is_x && !busy;
  assign capture = (state == RUN) && res_valid_i;
  assign wdata_w = WIDTH_W'($signed(in_d));

  assign err_set = (write && (((is_w || is_x) && busy)
                              || is_o || is_bad))
                   || (read && is_bad);
  assign err_clr = write && is_stat && in_d[2];

  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
    if (clr_cmd) err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clr_cmd) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (start_cmd) state_nx = START;
        START: state_nx = RUN;
        RUN:   if (res_valid_i) state_nx = DONE;
        DONE:  if (start_cmd) state_nx = START;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    start_o = 1'b0;
    down    = 1'b0;
    busy    = 1'b0;
    unique case (state)
      START: begin
        start_o = 1'b1;
        busy    = 1'b1;
      end
      RUN:  busy = 1'b1;
      DONE: down = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_stat: rdata = WIDTH'({err_q, down, busy});
      is_w: begin
`ifdef NN_MGR_WRDBK_EN
        for (int i = 0; i < N_W; i++)
          if (a == W_BASE + 32'(i))
            rdata = WIDTH'(w_q[i*WIDTH_W +: WIDTH_W]);
`endif
      end
      is_x: begin
`ifdef NN_MGR_WRDBK_EN
        for (int i = 0; i < LENGHT_I; i++)
          if (a == I_BASE + 32'(i))
            rdata = x_q[i*WIDTH +: WIDTH];
`endif
      end
      is_o: begin
        for (int i = 0; i < LENGHT_O; i++)
          if (a == O_BASE + 32'(i))
            rdata = o_q[i*WIDTH +: WIDTH];
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q   <= '0;
      x_q   <= '0;
      o_q   <= '0;
      err_q <= 1'b0;
      out_d <= '0;
      ready <= 1'b0;
      wr    <= 1'b0;
    end else begin
      ready <= read;
      wr    <= w_we;
      err_q <= err_d;
      if (read) out_d <= rdata;
      for (int i = 0; i < N_W; i++)
        if (w_we && a == W_BASE + 32'(i))
          w_q[i*WIDTH_W +: WIDTH_W] <= wdata_w;
      for (int i = 0; i < LENGHT_I; i++)
        if (x_we && a == I_BASE + 32'(i))
          x_q[i*WIDTH +: WIDTH] <= in_d;
      if (clr_cmd)      o_q <= '0;
      else if (capture) o_q <= res_i;
    end
  end

  assign w_o = w_q;
  assign x_o = x_q;

endmodule

// File: tb/tb_nn_reg_manager.sv
// Bench for nn_reg_manager: directed table, reset sequences, random traffic
// checked against a transaction-level model of the register map.
module tb_nn_reg_manager;

  localparam int NW = 8;
  localparam int LI = 2;
  localparam int LO = 2;
`ifdef NN_MGR_WRDBK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  address;
  logic        write, read;
  logic [3:0]  in_d, out_d;
  logic        ready, wr, down;
  logic [71:0] w_o;
  logic [7:0]  x_o;
  logic        start_o;
  logic        res_valid_i;
  logic [7:0]  res_i;

  always #5 clk = ~clk;

  nn_reg_manager #(
    .WIDTH(4), .WIDTH_W(9), .LENGHT_I(2),
    .LENGHT_MID(2), .LENGHT_O(2)
  ) dut (
    .clk(clk), .reset(reset),
    .address(address), .write(write),
    .read(read), .in_d(in_d),
    .out_d(out_d), .ready(ready),
    .wr(wr), .down(down),
    .w_o(w_o), .x_o(x_o),
    .start_o(start_o),
    .res_valid_i(res_valid_i),
    .res_i(res_i)
  );

  int checks = 0;
  int failures = 0;

  // model: 0 idle, 1 start issued, 2 waiting result, 3 done
  int m_w[NW];
  int m_x[LI];
  int m_o[LO];
  int m_ph;
  bit m_err;
  int m_rd;

  typedef struct {
    bit w;
    bit r;
    int ad;
    int dt;
    bit rv;
    int rs;
    int exp_rd;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(string nm,
                     logic [127:0] act,
                     logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_w[i]) m_w[i] = 0;
    foreach (m_x[i]) m_x[i] = 0;
    foreach (m_o[i]) m_o[i] = 0;
    m_ph  = 0;
    m_err = 1'b0;
    m_rd  = 0;
  endtask

  task automatic compare_all();
    logic [71:0] ew;
    logic [7:0]  ex;
    for (int i = 0; i < NW; i++)
      ew[i*9 +: 9] = 9'(m_w[i]);
    for (int i = 0; i < LI; i++)
      ex[i*4 +: 4] = 4'(m_x[i]);
    chk("w_o", w_o, ew);
    chk("x_o", x_o, ex);
    chk("start_o", start_o, m_ph == 1);
    chk("down", down, m_ph == 3);
    chk("out_d", out_d, m_rd);
  endtask

  task automatic step(input bit w, input bit r,
                      input int ad, input int dt,
                      input bit rv, input int rs,
                      input int exp_rd);
    bit busy, e_wr, st, clr;
    int n_ph, e_rd, v;
    busy = (m_ph == 1) || (m_ph == 2);
    e_rd = 0;
    if (r) begin
      if (ad == 1)
        e_rd = int'(busy) + 2*int'(m_ph == 3)
               + 4*int'(m_err);
      else if (ad >= 2 && ad < 2+NW)
        e_rd = RB ? (m_w[ad-2] % 16) : 0;
      else if (ad >= 2+NW && ad < 2+NW+LI)
        e_rd = RB ? m_x[ad-2-NW] : 0;
      else if (ad >= 2+NW+LI && ad < 2+NW+LI+LO)
        e_rd = m_o[ad-2-NW-LI];
      m_rd = e_rd;
    end
    clr = w && ad == 0 && dt[1];
    st  = w && ad == 0 && dt[0] && !dt[1];
    e_wr = w && ad >= 2 && ad < 2+NW && !busy;
    if (e_wr) begin
      v = (dt >= 8) ? dt - 16 : dt;
      m_w[ad-2] = v & 'h1FF;
    end
    if (w && !busy && ad >= 2+NW && ad < 2+NW+LI)
      m_x[ad-2-NW] = dt;
    if (w && ad == 1 && dt[2]) m_err = 1'b0;
    if ((w && ((ad >= 2 && ad < 2+NW+LI && busy)
               || ad >= 2+NW+LI))
        || (r && ad >= 2+NW+LI+LO))
      m_err = 1'b1;
    n_ph = m_ph;
    if (clr) begin
      n_ph = 0;
      m_err = 1'b0;
      foreach (m_o[i]) m_o[i] = 0;
    end else if ((m_ph == 0 || m_ph == 3) && st) begin
      n_ph = 1;
    end else if (m_ph == 1) begin
      n_ph = 2;
    end else if (m_ph == 2 && rv) begin
      n_ph = 3;
      m_o[0] = rs % 16;
      m_o[1] = (rs / 16) % 16;
    end
    write       = w;
    read        = r;
    address     = 4'(ad);
    in_d        = 4'(dt);
    res_valid_i = rv;
    res_i       = 8'(rs);
    @(posedge clk);
    #1;
    m_ph = n_ph;
    chk("ready", ready, r);
    chk("wr", wr, e_wr);
    compare_all();
    if (exp_rd >= 0)
      chk("table_rd", out_d, exp_rd);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, -1);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_start_o"}, start_o, 0);
    chk({tag, "_down"}, down, 0);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_wr"}, wr, 0);
    chk({tag, "_out_d"}, out_d, 0);
    chk({tag, "_w_o"}, w_o, 0);
    chk({tag, "_x_o"}, x_o, 0);
  endtask

  initial begin
    tbl[0]  = '{1, 0,  2, 15, 0, 0, -1};
    tbl[1]  = '{1, 0,  3,  3, 0, 0, -1};
    tbl[2]  = '{1, 0, 10,  1, 0, 0, -1};
    tbl[3]  = '{1, 0, 11,  2, 0, 0, -1};
    tbl[4]  = '{1, 1, 11,  5, 0, 0, RB ? 2 : 0};
    tbl[5]  = '{0, 1,  2,  0, 0, 0, RB ? 15 : 0};
    tbl[6]  = '{1, 0,  0,  1, 0, 0, -1};
    tbl[7]  = '{0, 1,  1,  0, 0, 0, 1};
    tbl[8]  = '{1, 0,  4,  6, 0, 0, -1};
    tbl[9]  = '{0, 1,  1,  0, 0, 0, 5};
    tbl[10] = '{1, 0,  1,  4, 0, 0, -1};
    tbl[11] = '{0, 1,  1,  0, 0, 0, 1};
    tbl[12] = '{0, 0,  0,  0, 1, 'hA7, -1};
    tbl[13] = '{0, 1, 12,  0, 0, 0, 7};
    tbl[14] = '{0, 1, 13,  0, 0, 0, 10};
    tbl[15] = '{0, 1,  1,  0, 0, 0, 2};
    tbl[16] = '{1, 0, 12,  3, 0, 0, -1};
    tbl[17] = '{0, 1, 15,  0, 0, 0, 0};
    tbl[18] = '{0, 1,  1,  0, 0, 0, 6};
    tbl[19] = '{1, 0,  0,  3, 0, 0, -1};
    tbl[20] = '{0, 1, 12,  0, 0, 0, 0};
    tbl[21] = '{0, 1,  1,  0, 0, 0, 0};
    tbl[22] = '{0, 1,  3,  0, 0, 0, RB ? 3 : 0};
    tbl[23] = '{0, 1, 11,  0, 0, 0, RB ? 5 : 0};

    reset = 1'b1;
    write = 0; read = 0; address = 0;
    in_d = 0; res_valid_i = 0; res_i = 0;
    model_reset();
    #12;
    chk_zero("rst");
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i])
      step(tbl[i].w, tbl[i].r, tbl[i].ad,
           tbl[i].dt, tbl[i].rv, tbl[i].rs,
           tbl[i].exp_rd);
    idle();
    chk("w_o_lo", w_o[8:0], 9'h1FF);
    chk("w_o_w1", w_o[17:9], 9'h003);
    chk("x_o_pair", x_o, 8'h51);

    // reset landing mid-run, then a late result
    step(1, 0, 0, 1, 0, 0, -1);
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk_zero("midrun");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0, 0, 1, 'hFF, -1);
    step(0, 1, 12, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      bit w, r, rv;
      int ad;
      w  = ($urandom_range(0, 1) == 1);
      r  = ($urandom_range(0, 1) == 1);
      rv = ($urandom_range(0, 2) == 0);
      ad = $urandom_range(0, 15);
      step(w, r, ad, $urandom_range(0, 15),
           rv, $urandom_range(0, 255), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
